// File: rtl/sm83_flags_pkg.sv
// Shared types for the SM83 flags bank: per-flag update ops and SM83 flag bit indices.
package sm83_flags_pkg;

    typedef enum logic [2:0] {
        OpHold = 3'd0,
        OpBus  = 3'd1,
        OpAlu  = 3'd2,
        OpSet  = 3'd3,
        OpClr  = 3'd4,
        OpCpl  = 3'd5
    } flag_op_e;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 3;

endpackage

// File: rtl/sm83_flags_bank_if.sv
// Bus-side signal bundle of the flags bank; the controller side is master, the bank is slave.
interface sm83_flags_bank_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned NF    = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0]   din;
    logic [DW-1:0]   dout;
    logic [3*NF-1:0] flag_op;
    logic [NF-1:0]   alu_in;
    logic [NF-1:0]   flags;
    logic            push;
    logic            pop;
    logic [CW-1:0]   stack_cnt;
    logic            stack_full;
    logic            stack_empty;
    logic            stack_err;

    modport master (
        output din, flag_op, alu_in, push, pop,
        input  dout, flags, stack_cnt, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  din, flag_op, alu_in, push, pop,
        output dout, flags, stack_cnt, stack_full, stack_empty, stack_err
    );

endinterface

// File: rtl/sm83_flags_stack.sv
// LIFO save stack for flag contexts with count, overflow/underflow detection and swap support.
// SM83_FLAGS_PARITY_EN adds an even-parity bit per entry, checked on every read-out.
module sm83_flags_stack #(
    parameter int unsigned NF    = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [NF-1:0]                wdata_i,
    output logic [NF-1:0]                rdata_o,
    output logic                         restore_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         err_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SM83_FLAGS_PARITY_EN
    localparam int unsigned EW = NF + 1;
`else
    localparam int unsigned EW = NF;
`endif

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          empty, full;
    logic [AW-1:0] top_idx, wr_idx;
    logic [EW-1:0] top_entry, wr_entry;
    logic          push_ok, pop_ok, swap, overflow, underflow, par_bad;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign top_idx   = empty ? '0 : AW'(cnt_q - CW'(1));
    assign wr_idx    = AW'(cnt_q);
    assign top_entry = mem_q[top_idx];

    // push+pop on an empty stack degrades to a plain push
    assign swap      = push_i & pop_i & ~empty;
    assign push_ok   = push_i & (~pop_i | empty) & ~full;
    assign overflow  = push_i & ~pop_i & full;
    assign pop_ok    = pop_i & ~push_i & ~empty;
    assign underflow = pop_i & ~push_i & empty;

`ifdef SM83_FLAGS_PARITY_EN
    assign wr_entry = {^wdata_i, wdata_i};
    assign par_bad  = (pop_ok | swap) & (^top_entry);
`else
    assign wr_entry = wdata_i;
    assign par_bad  = 1'b0;
`endif

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        err_d = err_q | overflow | underflow | par_bad;
        if (push_ok) begin
            mem_d[wr_idx] = wr_entry;
            cnt_d         = cnt_q + CW'(1);
        end
        if (swap) begin
            mem_d[top_idx] = wr_entry;
        end
        if (pop_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_o   = top_entry[NF-1:0];
    assign restore_o = pop_ok | swap;
    assign cnt_o     = cnt_q;
    assign full_o    = full;
    assign empty_o   = empty;
    assign err_o     = err_q;

endmodule

// File: rtl/sm83_flags_bank.sv
// Flags register bank: per-flag op decode plus context save stack with pop/swap restore.
// Optional SM83_FLAGS_PARITY_EN enables parity-protected stack entries.
module sm83_flags_bank
    import sm83_flags_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned NF    = 4,
    parameter int unsigned DEPTH = 4
) (
    input logic               clk,
    input logic               reset_n,
    sm83_flags_bank_if.slave  bus
);
    logic [NF-1:0] flags_q, flags_d;
    logic [NF-1:0] stack_rdata;
    logic          restore;

    sm83_flags_stack #(
        .NF    (NF),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (bus.push),
        .pop_i     (bus.pop),
        .wdata_i   (flags_q),
        .rdata_o   (stack_rdata),
        .restore_o (restore),
        .cnt_o     (bus.stack_cnt),
        .full_o    (bus.stack_full),
        .empty_o   (bus.stack_empty),
        .err_o     (bus.stack_err)
    );

    always_comb begin
        flags_d = flags_q;
        for (int i = 0; i < int'(NF); i++) begin
            case (flag_op_e'(bus.flag_op[3*i+:3]))
                OpBus:   flags_d[i] = bus.din[DW-NF+i];
                OpAlu:   flags_d[i] = bus.alu_in[i];
                OpSet:   flags_d[i] = 1'b1;
                OpClr:   flags_d[i] = 1'b0;
                OpCpl:   flags_d[i] = ~flags_q[i];
                default: flags_d[i] = flags_q[i];
            endcase
        end
        // A restore from the stack overrides every per-flag op.
        if (restore) begin
            flags_d = stack_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    always_comb begin
        bus.dout = '0;
        bus.dout[DW-1 -: NF] = flags_q;
    end

    assign bus.flags = flags_q;

endmodule

// File: tb/tb_sm83_flags_bank.sv
// Directed self-checking bench for sm83_flags_bank (default build, parity disabled).
module tb_sm83_flags_bank;
    import sm83_flags_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned NF    = 4;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sm83_flags_bank_if #(.DW(DW), .NF(NF), .DEPTH(DEPTH)) bus ();

    sm83_flags_bank #(.DW(DW), .NF(NF), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic logic [3*NF-1:0] all_ops(input flag_op_e op);
        logic [3*NF-1:0] r;
        for (int i = 0; i < int'(NF); i++) r[3*i+:3] = op;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flag_op = all_ops(OpHold);
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic load(input logic [NF-1:0] v);
        idle();
        bus.alu_in  = v;
        bus.flag_op = all_ops(OpAlu);
        step();
        idle();
    endtask

    task automatic test_reset();
        bus.din     = 8'hFF;
        bus.alu_in  = 4'hF;
        bus.flag_op = all_ops(OpSet);
        bus.push    = 1'b1;
        bus.pop     = 1'b0;
        reset_n     = 1'b0;
        step();
        checks++; if (bus.flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got=%h want=%h", bus.flags, 4'h0); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got=%h want=%h", bus.dout, 8'h00); end
        checks++; if (bus.stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got=%b want=1", bus.stack_empty); end
        checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL reset_err: got=%b want=0", bus.stack_err); end
        checks++; if (bus.stack_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got=%0d want=0", bus.stack_cnt); end
        reset_n = 1'b1;
        idle();
        step();
    endtask

    task automatic test_ops();
        logic [3*NF-1:0] v;
        bus.din     = 8'hA0;
        bus.flag_op = all_ops(OpBus);
        step();
        checks++; if (bus.flags !== 4'b1010) begin errors++; $display("FAIL bus_flags: got=%b want=1010", bus.flags); end
        checks++; if (bus.dout !== 8'hA0) begin errors++; $display("FAIL bus_dout: got=%h want=a0", bus.dout); end
        v = all_ops(OpHold);
        v[3*FLAG_Z+:3] = OpCpl;
        v[3*FLAG_C+:3] = OpSet;
        bus.flag_op = v;
        bus.din     = 8'h00;
        step();
        checks++; if (bus.dout !== 8'h30) begin errors++; $display("FAIL cpl_set_dout: got=%h want=30", bus.dout); end
        bus.flag_op = {4{3'd6}};
        bus.din     = 8'hF0;
        step();
        checks++; if (bus.flags !== 4'h3) begin errors++; $display("FAIL reserved_hold: got=%h want=3", bus.flags); end
        bus.alu_in  = 4'b0110;
        bus.flag_op = all_ops(OpAlu);
        step();
        checks++; if (bus.dout !== 8'h60) begin errors++; $display("FAIL alu_dout: got=%h want=60", bus.dout); end
        bus.flag_op = all_ops(OpClr);
        step();
        checks++; if (bus.flags !== 4'h0) begin errors++; $display("FAIL clr_flags: got=%h want=0", bus.flags); end
        idle();
    endtask

    task automatic test_push_pop();
        load(4'hB);
        bus.push    = 1'b1;
        bus.alu_in  = 4'h5;
        bus.flag_op = all_ops(OpAlu);
        step();
        checks++; if (bus.flags !== 4'h5) begin errors++; $display("FAIL push_op_flags: got=%h want=5", bus.flags); end
        checks++; if (bus.stack_cnt !== 3'd1) begin errors++; $display("FAIL push1_cnt: got=%0d want=1", bus.stack_cnt); end
        idle();
        bus.push = 1'b1;
        step();
        checks++; if (bus.stack_cnt !== 3'd2) begin errors++; $display("FAIL push2_cnt: got=%0d want=2", bus.stack_cnt); end
        idle();
        bus.flag_op = all_ops(OpClr);
        step();
        bus.flag_op = all_ops(OpSet);
        bus.pop     = 1'b1;
        step();
        checks++; if (bus.flags !== 4'h5) begin errors++; $display("FAIL pop1_flags: got=%h want=5", bus.flags); end
        step();
        checks++; if (bus.flags !== 4'hB) begin errors++; $display("FAIL pop2_flags: got=%h want=b", bus.flags); end
        checks++; if (bus.stack_empty !== 1'b1) begin errors++; $display("FAIL pop2_empty: got=%b want=1", bus.stack_empty); end
        checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL pop2_err: got=%b want=0", bus.stack_err); end
        idle();
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        for (int k = 0; k < int'(DEPTH); k++) begin
            bus.push = 1'b1;
            step();
            checks++;
            if (bus.stack_full !== (k == int'(DEPTH) - 1)) begin
                errors++; $display("FAIL fill_full[%0d]: got=%b want=%b", k, bus.stack_full, (k == int'(DEPTH) - 1));
            end
        end
        checks++; if (bus.stack_cnt !== 3'd4) begin errors++; $display("FAIL fill_cnt: got=%0d want=4", bus.stack_cnt); end
        checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL fill_err: got=%b want=0", bus.stack_err); end
        step();
        checks++; if (bus.stack_cnt !== 3'd4) begin errors++; $display("FAIL ovf_cnt: got=%0d want=4", bus.stack_cnt); end
        checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got=%b want=1", bus.stack_err); end
        idle();
        bus.pop = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) step();
        checks++; if (bus.stack_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got=%b want=1", bus.stack_empty); end
        bus.flag_op = all_ops(OpSet);
        step();
        checks++; if (bus.flags !== 4'hF) begin errors++; $display("FAIL unf_flags: got=%h want=f", bus.flags); end
        checks++; if (bus.stack_err !== 1'b1) begin errors++; $display("FAIL unf_err: got=%b want=1", bus.stack_err); end
        checks++; if (bus.stack_cnt !== 3'd0) begin errors++; $display("FAIL unf_cnt: got=%0d want=0", bus.stack_cnt); end
        idle();
    endtask

    task automatic test_swap();
        do_reset();
        load(4'h3);
        bus.push = 1'b1;
        step();
        idle();
        load(4'hC);
        bus.push    = 1'b1;
        bus.pop     = 1'b1;
        bus.flag_op = all_ops(OpSet);
        step();
        checks++; if (bus.flags !== 4'h3) begin errors++; $display("FAIL swap_flags: got=%h want=3", bus.flags); end
        checks++; if (bus.stack_cnt !== 3'd1) begin errors++; $display("FAIL swap_cnt: got=%0d want=1", bus.stack_cnt); end
        idle();
        bus.pop = 1'b1;
        step();
        checks++; if (bus.flags !== 4'hC) begin errors++; $display("FAIL swap_pop_flags: got=%h want=c", bus.flags); end
        checks++; if (bus.stack_cnt !== 3'd0) begin errors++; $display("FAIL swap_pop_cnt: got=%0d want=0", bus.stack_cnt); end
        bus.push    = 1'b1;
        bus.alu_in  = 4'h9;
        bus.flag_op = all_ops(OpAlu);
        step();
        checks++; if (bus.flags !== 4'h9) begin errors++; $display("FAIL empty_swap_flags: got=%h want=9", bus.flags); end
        checks++; if (bus.stack_cnt !== 3'd1) begin errors++; $display("FAIL empty_swap_cnt: got=%0d want=1", bus.stack_cnt); end
        checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL empty_swap_err: got=%b want=0", bus.stack_err); end
        idle();
        bus.pop = 1'b1;
        step();
        checks++; if (bus.flags !== 4'hC) begin errors++; $display("FAIL empty_swap_pop: got=%h want=c", bus.flags); end
        idle();
    endtask

    task automatic test_clean_restore();
        do_reset();
        load(4'h6);
        bus.push = 1'b1;
        step();
        idle();
        bus.flag_op = all_ops(OpClr);
        step();
        idle();
        bus.pop = 1'b1;
        step();
        checks++; if (bus.flags !== 4'h6) begin errors++; $display("FAIL restore_flags: got=%h want=6", bus.flags); end
        checks++; if (bus.stack_err !== 1'b0) begin errors++; $display("FAIL restore_err: got=%b want=0", bus.stack_err); end
        idle();
    endtask

    initial begin
        bus.din    = '0;
        bus.alu_in = '0;
        idle();
        reset_n = 1'b1;
        test_reset();
        test_ops();
        test_push_pop();
        test_overflow_underflow();
        test_swap();
        test_clean_restore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
